// File: rtl/line_sensor_pkg.sv
// Shared constants and FSM encoding for the line-sensor readout chain.
package line_sensor_pkg;
  localparam int PIXELS_DEF = 128;
  localparam int DATA_W_DEF = 12;
  localparam int OVR_W_DEF  = 8;
  localparam int IDX_W_DEF  = $clog2(PIXELS_DEF);

  // Index reported when a peak falls below the spot threshold.
  localparam logic [IDX_W_DEF-1:0] NO_SPOT_IDX = '1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  function automatic int idx_w_for(input int pixels);
    return $clog2(pixels);
  endfunction
endpackage

// File: rtl/line_peak_detector_if.sv
// Sample stream in / peak result out bundle for line_peak_detector.
// spot_thresh exists only when LINE_PEAK_THRESH_EN is defined.
interface line_peak_detector_if #(
  parameter int DATA_W = line_sensor_pkg::DATA_W_DEF,
  parameter int IDX_W  = line_sensor_pkg::IDX_W_DEF,
  parameter int OVR_W  = line_sensor_pkg::OVR_W_DEF
);
  logic              frame_start;
  logic              sample_valid;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
`ifdef LINE_PEAK_THRESH_EN
  logic [DATA_W-1:0] spot_thresh;
`endif
  logic              result_ready;
  logic              result_valid;
  logic [DATA_W-1:0] peak_val1;
  logic [IDX_W-1:0]  peak_idx1;
  logic [DATA_W-1:0] peak_val2;
  logic [IDX_W-1:0]  peak_idx2;
  logic              frame_error;
  logic [OVR_W-1:0]  overrun_count;

  modport master (
`ifdef LINE_PEAK_THRESH_EN
    output spot_thresh,
`endif
    output frame_start, sample_valid, data1, data2, result_ready,
    input  result_valid, peak_val1, peak_idx1, peak_val2, peak_idx2,
           frame_error, overrun_count
  );

  modport slave (
`ifdef LINE_PEAK_THRESH_EN
    input  spot_thresh,
`endif
    input  frame_start, sample_valid, data1, data2, result_ready,
    output result_valid, peak_val1, peak_idx1, peak_val2, peak_idx2,
           frame_error, overrun_count
  );
endinterface

// File: rtl/peak_tracker.sv
// Single-channel running max/argmax register for one frame.
// first forces a load so pixel 0 always wins; clear zeroes the working values.
module peak_tracker #(
  parameter int DATA_W = line_sensor_pkg::DATA_W_DEF,
  parameter int IDX_W  = line_sensor_pkg::IDX_W_DEF
) (
  input  logic              clk_20M,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample,
  input  logic              first,
  input  logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] max_val,
  output logic [IDX_W-1:0]  max_idx
);
  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (sample && (first || data > max_q)) begin
      max_d = data;
      idx_d = idx;
    end else if (clear) begin
      max_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign max_val = max_q;
  assign max_idx = idx_q;
endmodule

// File: rtl/line_peak_detector.sv
// Per-frame max/argmax of both ADC channels, held behind a valid/ready handshake.
// Define LINE_PEAK_THRESH_EN to add spot_thresh, which marks weak peaks with the no-spot index.
//   state    | meaning
//   ST_IDLE  | waiting for frame_start, samples ignored
//   ST_ACCUM | collecting pixels 0..PIXELS-1 of the current frame
module line_peak_detector
  import line_sensor_pkg::*;
#(
  parameter int PIXELS = PIXELS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = idx_w_for(PIXELS),
  parameter int OVR_W  = OVR_W_DEF
) (
  input logic           clk_20M,
  input logic           reset,
  line_peak_detector_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;

  logic              in_accum, completing, restart, take, first;
  logic [IDX_W-1:0]  pix_idx, load_idx1, load_idx2;
  logic [DATA_W-1:0] w_val1, w_val2;
  logic [IDX_W-1:0]  w_idx1, w_idx2;

  assign in_accum   = (state_q == ST_ACCUM);
  assign completing = in_accum && bus.sample_valid && (cnt_q == LAST_IDX);
  // A frame_start on the final sample belongs to the next frame and must not disturb this one.
  assign restart    = bus.frame_start && !completing;
  assign take       = bus.sample_valid && (in_accum || bus.frame_start);
  assign first      = restart || (cnt_q == '0);
  assign pix_idx    = restart ? '0 : cnt_q;

  peak_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_trk1 (
    .clk_20M(clk_20M), .reset(reset), .clear(restart), .sample(take), .first(first),
    .data(bus.data1), .idx(pix_idx), .max_val(w_val1), .max_idx(w_idx1)
  );

  peak_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_trk2 (
    .clk_20M(clk_20M), .reset(reset), .clear(restart), .sample(take), .first(first),
    .data(bus.data2), .idx(pix_idx), .max_val(w_val2), .max_idx(w_idx2)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = completing;
    err_d   = 1'b0;
    if (completing) begin
      state_d = bus.frame_start ? ST_ACCUM : ST_IDLE;
      cnt_d   = '0;
    end else if (bus.frame_start) begin
      state_d = ST_ACCUM;
      err_d   = in_accum;
      cnt_d   = bus.sample_valid ? IDX_W'(1) : '0;
    end else if (in_accum && bus.sample_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef LINE_PEAK_THRESH_EN
  localparam logic [IDX_W-1:0] NO_SPOT = '1;
  logic [DATA_W-1:0] thresh_q, thresh_d;

  always_comb begin
    thresh_d = completing ? bus.spot_thresh : thresh_q;
  end

  always_ff @(posedge clk_20M) begin
    if (reset) thresh_q <= '0;
    else       thresh_q <= thresh_d;
  end

  assign load_idx1 = (w_val1 < thresh_q) ? NO_SPOT : w_idx1;
  assign load_idx2 = (w_val2 < thresh_q) ? NO_SPOT : w_idx2;
`else
  assign load_idx1 = w_idx1;
  assign load_idx2 = w_idx2;
`endif

  // done_q marks the cycle the finished working values transfer to the result registers.
  always_comb begin
    valid_d = valid_q;
    val1_d  = val1_q;
    idx1_d  = idx1_q;
    val2_d  = val2_q;
    idx2_d  = idx2_q;
    ovr_d   = ovr_q;
    if (done_q) begin
      if (!valid_q || bus.result_ready) begin
        valid_d = 1'b1;
        val1_d  = w_val1;
        idx1_d  = load_idx1;
        val2_d  = w_val2;
        idx2_d  = load_idx2;
      end else if (ovr_q != '1) begin
        ovr_d = ovr_q + 1'b1;
      end
    end else if (valid_q && bus.result_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      val1_q  <= '0;
      idx1_q  <= '0;
      val2_q  <= '0;
      idx2_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      val1_q  <= val1_d;
      idx1_q  <= idx1_d;
      val2_q  <= val2_d;
      idx2_q  <= idx2_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.result_valid  = valid_q;
  assign bus.peak_val1     = val1_q;
  assign bus.peak_idx1     = idx1_q;
  assign bus.peak_val2     = val2_q;
  assign bus.peak_idx2     = idx2_q;
  assign bus.frame_error   = err_q;
  assign bus.overrun_count = ovr_q;
endmodule

// File: tb/tb_line_peak_detector.sv
// Bench for line_peak_detector: frame-level reference model (sample lists + argmax)
// checked every cycle, plus directed scenario checks and randomized frames.
module tb_line_peak_detector;
  localparam int PIXELS  = 128;
  localparam int DATA_W  = 12;
  localparam int IDX_W   = 7;
  localparam int OVR_W   = 8;
  localparam int DMASK   = (1 << DATA_W) - 1;
  localparam int NO_SPOT = (1 << IDX_W) - 1;
  localparam int OVR_MAX = (1 << OVR_W) - 1;

  logic clk_20M = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  bit   rand_rdy = 1'b0;
  int   data_mode = 0;
  bit   fs_prev = 1'b0;
  int   fr1_v1, fr1_i1, fr1_v2, fr1_i2;

  bit   m_in_frame, m_pend;
  int   m_q1[$];
  int   m_q2[$];
  int   p_v1, p_i1, p_v2, p_i2;
  bit   e_valid, e_err;
  int   e_v1, e_i1, e_v2, e_i2, e_ovr;

  always #25 clk_20M = ~clk_20M;

  line_peak_detector_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .OVR_W(OVR_W)) bus ();

  line_peak_detector #(.PIXELS(PIXELS), .DATA_W(DATA_W), .IDX_W(IDX_W), .OVR_W(OVR_W)) dut (
    .clk_20M(clk_20M),
    .reset(reset),
    .bus(bus)
  );

  function automatic void argmax(input int q[$], output int v, output int i);
    v = q[0];
    i = 0;
    foreach (q[k]) if (q[k] > v) begin v = q[k]; i = k; end
  endfunction

  function automatic void model_edge(input bit rst, input bit fs, input bit sv, input int d1,
                                     input int d2, input bit rdy, input int thr);
    if (rst) begin
      m_in_frame = 0; m_pend = 0; m_q1.delete(); m_q2.delete();
      e_valid = 0; e_err = 0; e_v1 = 0; e_i1 = 0; e_v2 = 0; e_i2 = 0; e_ovr = 0;
      return;
    end
    e_err = 0;
    if (m_pend) begin
      if (!e_valid || rdy) begin
        e_valid = 1; e_v1 = p_v1; e_i1 = p_i1; e_v2 = p_v2; e_i2 = p_i2;
      end else if (e_ovr < OVR_MAX) begin
        e_ovr++;
      end
    end else if (e_valid && rdy) begin
      e_valid = 0;
    end
    m_pend = 0;
    if (m_in_frame && sv && m_q1.size() == PIXELS - 1) begin
      m_q1.push_back(d1); m_q2.push_back(d2);
      argmax(m_q1, p_v1, p_i1);
      argmax(m_q2, p_v2, p_i2);
      if (p_v1 < thr) p_i1 = NO_SPOT;
      if (p_v2 < thr) p_i2 = NO_SPOT;
      m_pend = 1;
      m_q1.delete(); m_q2.delete();
      m_in_frame = fs;
    end else if (fs) begin
      if (m_in_frame) e_err = 1;
      m_q1.delete(); m_q2.delete();
      m_in_frame = 1;
      if (sv) begin m_q1.push_back(d1); m_q2.push_back(d2); end
    end else if (m_in_frame && sv) begin
      m_q1.push_back(d1); m_q2.push_back(d2);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit fs, input bit sv, input int d1, input int d2);
    int thr;
    thr = 0;
    if (rand_rdy) bus.result_ready = 1'($urandom_range(0, 1));
    bus.frame_start  = fs;
    bus.sample_valid = sv;
    bus.data1        = DATA_W'(d1);
    bus.data2        = DATA_W'(d2);
`ifdef LINE_PEAK_THRESH_EN
    thr = int'(bus.spot_thresh);
`endif
    @(posedge clk_20M);
    model_edge(reset, fs, sv, d1 & DMASK, d2 & DMASK, bus.result_ready, thr);
    @(negedge clk_20M);
    chk("result_valid", bus.result_valid, e_valid);
    chk("frame_error", bus.frame_error, e_err);
    chk("overrun_count", bus.overrun_count, e_ovr);
    if (e_valid) begin
      chk("peak_val1", bus.peak_val1, e_v1);
      chk("peak_idx1", bus.peak_idx1, e_i1);
      chk("peak_val2", bus.peak_val2, e_v2);
      chk("peak_idx2", bus.peak_idx2, e_i2);
    end
  endtask

  function automatic int pick();
    return (data_mode == 1) ? $urandom_range(0, 7) : $urandom_range(0, DMASK);
  endfunction

  task automatic run_frame(input bit do_start, input int len, input int gap, input bit fs_last);
    if (do_start) step(1, 0, 0, 0);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 99) < gap) step(0, 0, $urandom, $urandom);
      step(fs_last && (i == len - 1), 1, pick(), pick());
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_start = 0; bus.sample_valid = 0; bus.data1 = 0; bus.data2 = 0;
    bus.result_ready = 1;
`ifdef LINE_PEAK_THRESH_EN
    bus.spot_thresh = 0;
`endif
    @(negedge clk_20M);
    step(0, 0, 0, 0);
    step(0, 1, 'hFFF, 'hFFF);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_val1", bus.peak_val1, 0);
    chk("rst_idx2", bus.peak_idx2, 0);
    chk("rst_ovr", bus.overrun_count, 0);
    reset = 1'b0;

    // samples in IDLE are ignored
    repeat (3) step(0, 1, $urandom, $urandom);

    // ramp frame
    step(1, 0, 0, 0);
    for (int i = 0; i < PIXELS; i++) step(0, 1, i, PIXELS - 1 - i);
    chk("ramp_latency", bus.result_valid, 0);
    step(0, 0, 0, 0);
    chk("ramp_valid", bus.result_valid, 1);
    chk("ramp_val1", bus.peak_val1, 127);
    chk("ramp_idx1", bus.peak_idx1, 127);
    chk("ramp_val2", bus.peak_val2, 127);
    chk("ramp_idx2", bus.peak_idx2, 0);
    step(0, 0, 0, 0);

    // tie keeps lower index
    step(1, 0, 0, 0);
    for (int i = 0; i < PIXELS; i++) step(0, 1, (i == 10 || i == 50) ? 'h800 : 'h100, pick());
    step(0, 0, 0, 0);
    chk("tie_idx1", bus.peak_idx1, 10);
    chk("tie_val1", bus.peak_val1, 'h800);

    // short frame, restart with coincident sample as pixel 0
    data_mode = 1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, pick(), pick());
    step(1, 1, 'hFFF, 3);
    chk("short_err", bus.frame_error, 1);
    for (int i = 1; i < PIXELS; i++) begin
      step(0, 1, pick(), pick());
      if (i == 1) chk("short_err_once", bus.frame_error, 0);
    end
    step(0, 0, 0, 0);
    chk("short_valid", bus.result_valid, 1);
    chk("short_idx1", bus.peak_idx1, 0);
    chk("short_val1", bus.peak_val1, 'hFFF);

    // frame_start coincident with final sample
    data_mode = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < PIXELS; i++) step(i == PIXELS - 1, 1, pick(), pick());
    step(0, 0, 0, 0);
    chk("coinc_no_err", bus.frame_error, 0);
    chk("coinc_valid", bus.result_valid, 1);
    for (int i = 0; i < PIXELS; i++) step(0, 1, pick(), pick());
    step(0, 0, 0, 0);
    chk("coinc_next_valid", bus.result_valid, 1);
    step(0, 0, 0, 0);

    // backpressure across three frames
    bus.result_ready = 0;
    run_frame(1, PIXELS, 10, 0);
    step(0, 0, 0, 0);
    fr1_v1 = e_v1; fr1_i1 = e_i1; fr1_v2 = e_v2; fr1_i2 = e_i2;
    run_frame(1, PIXELS, 10, 0);
    run_frame(1, PIXELS, 10, 0);
    repeat (2) step(0, 0, 0, 0);
    chk("bp_ovr", bus.overrun_count, 2);
    chk("bp_valid", bus.result_valid, 1);
    chk("bp_held_val1", bus.peak_val1, fr1_v1);
    chk("bp_held_idx1", bus.peak_idx1, fr1_i1);
    chk("bp_held_val2", bus.peak_val2, fr1_v2);
    chk("bp_held_idx2", bus.peak_idx2, fr1_i2);
    bus.result_ready = 1;
    step(0, 0, 0, 0);
    chk("bp_release", bus.result_valid, 0);

    // reset at pixel 64
    step(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, pick(), pick());
    reset = 1'b1;
    step(0, 1, pick(), pick());
    reset = 1'b0;
    chk("mrst_valid", bus.result_valid, 0);
    chk("mrst_ovr", bus.overrun_count, 0);
    chk("mrst_val1", bus.peak_val1, 0);
    chk("mrst_err", bus.frame_error, 0);
    step(0, 1, pick(), pick());
    chk("mrst_no_err", bus.frame_error, 0);
    run_frame(1, PIXELS, 0, 0);
    step(0, 0, 0, 0);
    chk("mrst_next_valid", bus.result_valid, 1);
    step(0, 0, 0, 0);

`ifdef LINE_PEAK_THRESH_EN
    bus.spot_thresh = 'h400;
    step(1, 0, 0, 0);
    for (int i = 0; i < PIXELS; i++)
      step(0, 1, (i == 5) ? 'h3FF : (i % 'h100), (i == 20) ? 'h400 : 'h0FF);
    step(0, 0, 0, 0);
    chk("thr_idx1", bus.peak_idx1, NO_SPOT);
    chk("thr_val1", bus.peak_val1, 'h3FF);
    chk("thr_idx2", bus.peak_idx2, 20);
    chk("thr_val2", bus.peak_val2, 'h400);
    step(0, 0, 0, 0);
`endif

    // randomized frames, gaps, short frames, coincident starts and backpressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int len;
      bit fl;
      data_mode = $urandom_range(0, 1);
`ifdef LINE_PEAK_THRESH_EN
      bus.spot_thresh = DATA_W'($urandom_range(0, DMASK));
`endif
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, PIXELS - 1) : PIXELS;
      fl  = ($urandom_range(0, 3) == 0);
      run_frame(!fs_prev, len, 20, fl);
      fs_prev = fl;
      repeat ($urandom_range(0, 3)) step(0, 0, pick(), pick());
    end
    rand_rdy = 1'b0;
    bus.result_ready = 1;
    repeat (4) step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_peak_detector.md
Name: line_peak_detector

Overview:
- Sits directly downstream of the dual-channel ADC control stage.
- Consumes the two 12-bit pixel streams (channel 1 and channel 2) produced once per sensor clock during each linear-array readout.
- Per frame (one SI pulse followed by PIXELS samples), reports each channel's maximum intensity and the pixel index where it occurs. Holds the result behind a valid/ready handshake for the downstream consumer (soft-core GPIO or UART packetiser).

Parameters:
- PIXELS, 128, number of pixels per frame. Must be ≥ 2.
- DATA_W, 12, sample width.
- IDX_W, 7, pixel index width. Must satisfy 2^IDX_W ≥ PIXELS.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk_20M  in  1  system clock; same domain as the ADC stage.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse, aligned to the SI sample-control pulse.
- sample_valid  in  1  one-cycle pulse; data1/data2 valid this cycle.
- data1  in  DATA_W  channel 1 pixel sample.
- data2  in  DATA_W  channel 2 pixel sample.
- result_ready  in  1  consumer accepts the result.
- result_valid  out  1  result registers hold a complete frame.
- peak_val1  out  DATA_W  channel 1 maximum.
- peak_idx1  out  IDX_W  channel 1 index of the maximum.
- peak_val2  out  DATA_W  channel 2 maximum.
- peak_idx2  out  IDX_W  channel 2 index of the maximum.
- frame_error  out  1  one-cycle pulse when a short frame is discarded.
- overrun_count  out  OVR_W  frames dropped because the result was unconsumed. Saturates.

Behaviour:
- Reset:
  - FSM → IDLE.
  - result_valid=0; all peak_* = 0.
  - frame_error=0; overrun_count=0.
  - Pixel counter and working max/idx registers = 0.
- FSM states: IDLE, ACCUM.
- IDLE:
  - sample_valid is ignored.
  - frame_start → ACCUM; counter=0; working max=0; working idx=0.
  - If sample_valid coincides with frame_start, that sample is pixel 0 and is accumulated (counter→1).
- ACCUM, per sample_valid:
  - Compare each channel independently. Strictly greater (data > working max) updates max and idx := counter.
  - Ties keep the lower index. Pixel 0 always loads, including value 0.
  - counter increments.
- Frame completion:
  - Occurs when sample_valid arrives with counter == PIXELS-1. Final comparison includes that sample.
  - FSM → IDLE.
  - Working results transfer to the output registers on the following edge, so result_valid rises 1 cycle after the last sample's edge.
- frame_start during ACCUM with counter < PIXELS-1 (short frame):
  - Discard partial results.
  - Pulse frame_error for 1 cycle.
  - Restart ACCUM as for a fresh frame_start, including a coincident sample as pixel 0.
- frame_start coincident with the final sample:
  - The final sample completes the frame normally.
  - The new frame starts (→ ACCUM, counter=0).
  - No error.
- Output handshake:
  - result_valid stays high and peak_* stay stable until a cycle with result_valid & result_ready. The clear takes effect on the next edge.
  - Completion in the same cycle as a handshake: the new result loads and result_valid stays 1.
  - Completion while result_valid=1 and no handshake that cycle: the new result is dropped, output registers are unchanged, and overrun_count increments, saturating at 2^OVR_W-1.
- Mid-frame reset: the partial frame is discarded silently, with no frame_error.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: LINE_PEAK_THRESH_EN.
- When defined:
  - Adds input port spot_thresh (DATA_W).
  - Per channel, at completion, a peak < spot_thresh is stored with peak_idx forced to all-ones (no spot) and peak_val = the actual peak.
  - Threshold is sampled at the completion cycle.
- When undefined:
  - No port is added.
  - Index is always the true argmax.

Decomposition:
- Shared package line_sensor_pkg:
  - DATA_W and PIXELS defaults.
  - IDX_W derivation ($clog2(PIXELS)).
  - FSM state encoding.
  - NO_SPOT_IDX constant (all-ones).
- One natural sub-module, peak_tracker: a single-channel max/argmax register with load/update/clear controls. Instantiated twice, once per channel.

Test Plan:
- Ramp frame:
  - Stimulus: PIXELS=128; frame_start, then data1=i, data2=127-i for i=0..127; result_ready=1.
  - Response: peak_val1=127, peak_idx1=127, peak_val2=127, peak_idx2=0. result_valid rises 1 cycle after the last sample.
- Tie:
  - Stimulus: data1=0x800 at pixels 10 and 50, all others 0x100.
  - Response: peak_idx1=10.
- Short frame:
  - Stimulus: frame_start, 60 samples, then frame_start with a coincident sample.
  - Response: frame_error pulses once; the next full frame reports correctly, with the coincident sample counted as pixel 0.
- Backpressure:
  - Stimulus: result_ready=0 across 3 complete frames.
  - Response: the first frame's result is held, overrun_count=2. Asserting result_ready for 1 cycle drops result_valid on the next edge.
- Reset at pixel 64:
  - Response: all outputs 0 and no frame_error. The following full frame is correct.
- LINE_PEAK_THRESH_EN defined:
  - Stimulus: spot_thresh=0x400; channel 1 max 0x3FF, channel 2 max 0x400 at pixel 20.
  - Response: peak_idx1=127 (all-ones) with peak_val1=0x3FF; peak_idx2=20.
